// File: rtl/ram_master_if.sv
// Command, write-beat, read-beat and RAM-side signals of the burst RAM master.
// The master modport is the controller's view; the slave modport is the environment's view.
interface ram_master_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  done;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we_n;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, mem_rdata,
    output cmd_ready, wr_ready, rd_data, rd_valid, done, mem_addr, mem_wdata, mem_we_n
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, mem_rdata,
    input  cmd_ready, wr_ready, rd_data, rd_valid, done, mem_addr, mem_wdata, mem_we_n
  );
endinterface

// File: rtl/ram_master.sv
// Burst controller for a single-port RAM with one-cycle registered read data.
// Accepts write/read bursts of cmd_len+1 beats on incrementing, wrapping addresses.
module ram_master #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input logic          clk,
  input logic          rst,
  ram_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic [LEN_WIDTH-1:0]  cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  mem_we_n_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  done_q;
  logic                  issued_q;

  assign addr_d = addr_q + ADDR_WIDTH'(1);
  assign cnt_d  = cnt_q - LEN_WIDTH'(1);

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.wr_ready  = (state_q == WRITE);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we_n  = mem_we_n_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.done      = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_n_q  <= 1'b1;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      issued_q    <= 1'b0;
    end else begin
      mem_we_n_q <= 1'b1;
      issued_q   <= 1'b0;
      // Data for the address issued last cycle is on mem_rdata now.
      rd_valid_q <= issued_q;
      if (issued_q) rd_data_q <= bus.mem_rdata;
      done_q <= (state_q == DONE);

      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            addr_q  <= bus.cmd_addr;
            cnt_q   <= bus.cmd_len;
            state_q <= bus.cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (bus.wr_valid) begin
            mem_addr_q  <= addr_q;
            mem_wdata_q <= bus.wr_data;
            mem_we_n_q  <= 1'b0;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            if (cnt_q == '0) state_q <= DONE;
          end
        end
        READ: begin
          mem_addr_q <= addr_q;
          issued_q   <= 1'b1;
          addr_q     <= addr_d;
          cnt_q      <= cnt_d;
          if (cnt_q == '0) state_q <= DRAIN;
        end
        DRAIN:   state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
